tx_engine: RTL and testbench

- UART transmit engine: serialises one byte per `load` strobe into an 11-bit-time asynchronous frame on `tx`.
- Emits a one-clock `tx_done` pulse at end of frame. `tx_done` drives the set input of the TXRDY status flop; the CPU write strobe drives that flop's reset input.
- Sits between the CPU/port write decode and the serial output pin.

---
 rtl/tx_engine.sv | 77 +++++++
 tb/tb_tx_engine.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/tx_engine.sv
// tx_engine: UART transmit engine, serialises one byte per load strobe into an 11-bit-time frame.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset
//   load     : one-clock write strobe, accepted only when not busy
//   out_port : byte to transmit
//   eight    : 1 = 8 data bits, 0 = 7 data bits
//   pen      : parity enable
//   ohel     : parity sense, 1 = odd, 0 = even
//   k        : clocks per bit time, 0 treated as 1
//   tx       : serial line, idle high
//   busy     : frame in progress
//   tx_done  : one-clock pulse at end of frame
module tx_engine #(
    parameter int BK_W = 19
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [7:0]      out_port,
    input  logic            eight,
    input  logic            pen,
    input  logic            ohel,
    input  logic [BK_W-1:0] k,
    output logic            tx,
    output logic            busy,
    output logic            tx_done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nxt;
    logic [10:0] sr;
    logic [3:0] bit_cnt;
    logic [BK_W-1:0] baud, k_m1;
    logic accept, bit_end, b8, b9;
    assign accept = load && state != SHIFT;
    assign bit_end = baud == '0;
    assign busy = state == SHIFT;
    assign tx_done = state == DONE;
    // sr[0] is the bit currently on the line; outside a frame the line idles high
    assign tx = busy ? sr[0] : 1'b1;
    assign b8 = eight ? out_port[7] : (pen ? (^out_port[6:0]) ^ ohel : 1'b1);
    assign b9 = (eight && pen) ? (^out_port) ^ ohel : 1'b1;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = load ? SHIFT : IDLE;
            SHIFT:   state_nxt = (bit_end && bit_cnt == 4'd10) ? DONE : SHIFT;
            DONE:    state_nxt = load ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // baud counts down from K-1 so each bit is held exactly K clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
            bit_cnt <= '0;
            baud <= '0;
            k_m1 <= '0;
        end else if (accept) begin
            sr <= {1'b1, b9, b8, out_port[6:0], 1'b0};
            bit_cnt <= '0;
            baud <= (k == '0) ? '0 : k - 1'b1;
            k_m1 <= (k == '0) ? '0 : k - 1'b1;
        end else if (busy) begin
            if (bit_end) begin
                sr <= {1'b1, sr[10:1]};
                bit_cnt <= bit_cnt + 4'd1;
                baud <= k_m1;
            end else begin
                baud <= baud - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tx_engine.sv
// tb_tx_engine: directed scoreboard bench for tx_engine
module tb_tx_engine;
    logic clk = 0, reset = 1, load = 0, eight = 0, pen = 0, ohel = 0;
    logic [7:0] out_port = 0;
    logic [18:0] k = 0;
    logic tx, busy, tx_done;
    logic exp_q[$];
    int checks = 0, errors = 0;

    tx_engine #(.BK_W(19)) dut (
        .clk(clk), .reset(reset), .load(load), .out_port(out_port),
        .eight(eight), .pen(pen), .ohel(ohel), .k(k),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d, input logic e, input logic p, input logic o);
        logic par7, par8, b8, b9;
        par7 = (^d[6:0]) ^ o;
        par8 = (^d) ^ o;
        case ({e, p})
            2'b00:   begin b8 = 1'b1; b9 = 1'b1; end
            2'b01:   begin b8 = par7; b9 = 1'b1; end
            2'b10:   begin b8 = d[7]; b9 = 1'b1; end
            default: begin b8 = d[7]; b9 = par8; end
        endcase
        return {1'b1, b9, b8, d[6:0], 1'b0};
    endfunction

    // drive a load and push the expected per-clock tx line of the whole frame
    task automatic start(input logic [7:0] d, input logic e, input logic p, input logic o, input int kk);
        logic [10:0] f;
        int ke;
        ke = (kk == 0) ? 1 : kk;
        f = frame_of(d, e, p, o);
        out_port = d; eight = e; pen = p; ohel = o; k = kk[18:0];
        load = 1;
        for (int i = 0; i < 11; i++)
            for (int j = 0; j < ke; j++) exp_q.push_back(f[i]);
    endtask

    // runs from the accepting edge through the frame; returns in the tx_done cycle
    task automatic frame(input int ke, input bit mid);
        tick();
        load = 0;
        for (int i = 0; i < 11 * ke; i++) begin
            chk("tx_bit", {7'd0, tx}, {7'd0, exp_q.pop_front()});
            chk("busy_frame", {7'd0, busy}, 8'd1);
            chk("done_frame", {7'd0, tx_done}, 8'd0);
            if (mid) begin
                if (i == 3) begin
                    load = 1; out_port = 8'h00; eight = 0; pen = 1; ohel = 1; k = 19'd7;
                end
                if (i == 4) load = 0;
            end
            tick();
        end
        chk("done_pulse", {7'd0, tx_done}, 8'd1);
        chk("busy_done", {7'd0, busy}, 8'd0);
        chk("tx_done_idle", {7'd0, tx}, 8'd1);
    endtask

    initial begin
        tick();
        chk("rst_tx", {7'd0, tx}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, tx_done}, 8'd0);
        reset = 0;
        tick();
        chk("idle_tx", {7'd0, tx}, 8'd1);

        start(8'h55, 1, 0, 0, 4);
        frame(4, 0);
        tick();
        chk("post_done", {7'd0, tx_done}, 8'd0);

        start(8'h07, 0, 1, 0, 2);
        frame(2, 0);
        tick();
        start(8'h07, 0, 1, 1, 2);
        frame(2, 0);
        tick();

        start(8'hFF, 1, 1, 1, 3);
        frame(3, 0);
        tick();

        start(8'hA3, 1, 1, 0, 0);
        frame(1, 1);
        start(8'h3C, 1, 0, 0, 0);
        frame(1, 0);
        tick();
        chk("idle_after_b2b", {7'd0, busy}, 8'd0);

        start(8'h00, 1, 0, 0, 5);
        tick();
        load = 0;
        for (int i = 0; i < 22; i++) begin
            chk("pre_rst_bit", {7'd0, tx}, {7'd0, exp_q.pop_front()});
            tick();
        end
        reset = 1;
        #1;
        chk("async_rst_tx", {7'd0, tx}, 8'd1);
        chk("async_rst_busy", {7'd0, busy}, 8'd0);
        chk("async_rst_done", {7'd0, tx_done}, 8'd0);
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_hold_done", {7'd0, tx_done}, 8'd0);
        end
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", {7'd0, tx_done}, 8'd0);
            chk("abort_idle", {7'd0, tx}, 8'd1);
        end
        start(8'h81, 1, 0, 0, 5);
        frame(5, 0);
        tick();
        chk("final_idle", {7'd0, busy}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
